cpu_run_controller: RTL and testbench

//  Sequences the pipelined CPU core: streams a program into its instruction memory,

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/prog_loader.sv | 83 ++++++++
 rtl/cpu_run_controller.sv | 165 ++++++++++++++++
 tb/tb_cpu_run_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and sizing for the CPU run controller and its program loader.
package cpu_ctrl_pkg;

  localparam int MAX_WORDS  = 256;
  localparam int PIPE_DEPTH = 4;
  localparam int RUN_W      = 16;
  localparam int LEN_W      = 9;
  localparam int PIPE_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_FILL  = 3'd3,
    ST_RUN   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams program words into instruction memory: word counter, address generator,
// and registered s_ready / load strobe with one cycle of latency.
module prog_loader
  import cpu_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] prog_len_i,
  input  logic [31:0]      prog_base_i,
  input  logic             s_valid_i,
  input  logic [31:0]      s_data_i,
  output logic             s_ready_o,
  output logic             load_enable_o,
  output logic [31:0]      load_address_o,
  output logic [31:0]      load_data_o,
  output logic             last_o
);

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [31:0]      base_q, base_d;
  logic             ready_q, ready_d;
  logic             strobe_q, strobe_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             accept;

  // An abort in the same cycle as a handshake discards the word: the core is left in reset.
  assign accept = ready_q & s_valid_i & ~abort_i;

  always_comb begin
    len_d    = len_q;
    idx_d    = idx_q;
    base_d   = base_q;
    ready_d  = ready_q;
    strobe_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (start_i) begin
      len_d   = prog_len_i;
      base_d  = prog_base_i;
      idx_d   = '0;
      ready_d = 1'b1;
    end else if (abort_i) begin
      ready_d = 1'b0;
    end else if (accept) begin
      idx_d    = idx_q + LEN_W'(1);
      ready_d  = (idx_d < len_q);
      strobe_d = 1'b1;
      addr_d   = base_q + {{(32-LEN_W-2){1'b0}}, idx_q, 2'b00};
      data_d   = s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      len_q    <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      len_q    <= len_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      ready_q  <= ready_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign s_ready_o      = ready_q;
  assign load_enable_o  = strobe_q;
  assign load_address_o = addr_q;
  assign load_data_o    = data_q;
  assign last_o         = strobe_q && (idx_q == len_q);

endmodule

// File: rtl/cpu_run_controller.sv
// Load / prime / fill / run / drain sequencer for the pipelined CPU core.
//  state | meaning
//  IDLE  | waiting for start, core held in reset
//  LOAD  | streaming program words into instruction memory
//  PRIME | one cycle with base_pc stable before core release
//  FILL  | fetching, writeback gated, PIPE_DEPTH cycles
//  RUN   | fetching and writing back, bounded by budget or halt
//  DRAIN | no fetch, in-flight writes retire, PIPE_DEPTH cycles
//  DONE  | job finished; core reset only if the job failed
module cpu_run_controller
  import cpu_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] prog_len_i,
  input  logic [31:0]      prog_base_i,
  input  logic [RUN_W-1:0] run_cycles_i,
  input  logic             halt_req_i,
  input  logic             s_valid_i,
  input  logic [31:0]      s_data_i,
  output logic             s_ready_o,
  output logic             cpu_reset_o,
  output logic             load_enable_o,
  output logic [31:0]      load_address_o,
  output logic [31:0]      load_data_o,
  output logic [31:0]      base_pc_o,
  output logic             fetch_enable_o,
  output logic             reg_write_enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      cycle_count_o
);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [PIPE_W-1:0] pipe_cnt_q, pipe_cnt_d;
  logic [31:0]      base_pc_q, base_pc_d;
  logic [31:0]      cycle_cnt_q, cycle_cnt_d;
  logic             err_q, err_d;
  logic             start_acc, len_good, load_last, loader_abort;

  assign start_acc    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign len_good     = len_ok(prog_len_i);
  assign loader_abort = (state_q == ST_LOAD) && halt_req_i;

  prog_loader u_loader (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_acc && len_good),
    .abort_i        (loader_abort),
    .prog_len_i     (prog_len_i),
    .prog_base_i    (prog_base_i),
    .s_valid_i      (s_valid_i),
    .s_data_i       (s_data_i),
    .s_ready_o      (s_ready_o),
    .load_enable_o  (load_enable_o),
    .load_address_o (load_address_o),
    .load_data_o    (load_data_o),
    .last_o         (load_last)
  );

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    run_cnt_d   = run_cnt_q;
    pipe_cnt_d  = pipe_cnt_q;
    base_pc_d   = base_pc_q;
    err_d       = err_q;
    cycle_cnt_d = cycle_cnt_q;

    if (((state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
        (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          run_len_d   = run_cycles_i;
          base_pc_d   = prog_base_i;
          cycle_cnt_d = '0;
          err_d       = !len_good;
          state_d     = len_good ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (halt_req_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (load_last) begin
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        pipe_cnt_d = PIPE_W'(PIPE_DEPTH - 1);
        state_d    = ST_FILL;
      end
      ST_FILL: begin
        if (halt_req_i) begin
          pipe_cnt_d = PIPE_W'(PIPE_DEPTH - 1);
          state_d    = ST_DRAIN;
        end else if (pipe_cnt_q == '0) begin
          run_cnt_d = RUN_W'(1);
          state_d   = ST_RUN;
        end else begin
          pipe_cnt_d = pipe_cnt_q - PIPE_W'(1);
        end
      end
      ST_RUN: begin
        // run_cnt_q counts the current RUN cycle, starting at 1.
        if (halt_req_i || ((run_len_q != '0) && (run_cnt_q == run_len_q))) begin
          pipe_cnt_d = PIPE_W'(PIPE_DEPTH - 1);
          state_d    = ST_DRAIN;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      ST_DRAIN: begin
        if (pipe_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          pipe_cnt_d = pipe_cnt_q - PIPE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      run_len_q   <= '0;
      run_cnt_q   <= '0;
      pipe_cnt_q  <= '0;
      base_pc_q   <= '0;
      err_q       <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      run_cnt_q   <= run_cnt_d;
      pipe_cnt_q  <= pipe_cnt_d;
      base_pc_q   <= base_pc_d;
      err_q       <= err_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // A failed job never released the core, so it stays in reset through DONE.
  assign cpu_reset_o        = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                              (state_q == ST_PRIME) || ((state_q == ST_DONE) && err_q);
  assign busy_o             = (state_q == ST_LOAD) || (state_q == ST_PRIME) ||
                              (state_q == ST_FILL) || (state_q == ST_RUN) ||
                              (state_q == ST_DRAIN);
  assign done_o             = (state_q == ST_DONE);
  assign fetch_enable_o     = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign reg_write_enable_o = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign err_o              = err_q;
  assign base_pc_o          = base_pc_q;
  assign cycle_count_o      = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: load scoreboard plus per-scenario phase checks.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  prog_len = '0;
  logic [31:0] prog_base = '0;
  logic [15:0] run_cycles = '0;
  logic        halt = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, cpu_reset, load_enable, fetch, rw, busy, done, err;
  logic [31:0] load_address, load_data, base_pc, cycle_count;

  int total = 0;
  int bad = 0;
  int strobes = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  cpu_run_controller dut (
    .clk_i              (clk),
    .reset_i            (reset_n),
    .start_i            (start),
    .prog_len_i         (prog_len),
    .prog_base_i        (prog_base),
    .run_cycles_i       (run_cycles),
    .halt_req_i         (halt),
    .s_valid_i          (s_valid),
    .s_data_i           (s_data),
    .s_ready_o          (s_ready),
    .cpu_reset_o        (cpu_reset),
    .load_enable_o      (load_enable),
    .load_address_o     (load_address),
    .load_data_o        (load_data),
    .base_pc_o          (base_pc),
    .fetch_enable_o     (fetch),
    .reg_write_enable_o (rw),
    .busy_o             (busy),
    .done_o             (done),
    .err_o              (err),
    .cycle_count_o      (cycle_count)
  );

  // Scoreboard: every strobe must match the oldest accepted word.
  always @(negedge clk) begin
    if (load_enable) begin
      strobes++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra_strobe addr=%h data=%h expected no strobe", load_address, load_data);
      end else begin
        mon_e = sb.pop_front();
        if (load_address !== mon_e.addr || load_data !== mon_e.data) begin
          bad++;
          $display("FAIL sb_word got addr=%h data=%h exp addr=%h data=%h",
                   load_address, load_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic do_start(input logic [8:0] len, input logic [31:0] base, input logic [15:0] rc);
    prog_len   = len;
    prog_base  = base;
    run_cycles = rc;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] base, input bit toggle);
    int sent;
    int k;
    sent = 0;
    k = 0;
    while (sent < n && k < 100) begin
      s_valid = toggle ? ((k % 2) == 0) : 1'b1;
      s_data  = $urandom;
      if (s_valid && s_ready) begin
        sb.push_back('{base + 32'(4 * sent), s_data});
        sent++;
      end
      @(negedge clk);
      k++;
    end
    s_valid = 1'b0;
    total++;
    if (sent !== n) begin
      bad++;
      $display("FAIL feed_timeout sent=%0d exp=%0d", sent, n);
    end
  endtask

  task automatic run_phases(input int halt_fill, input int halt_run, input int start_run,
                            output int prime, output int fill, output int run,
                            output int drain, output bit fin);
    int k;
    prime = 0; fill = 0; run = 0; drain = 0; fin = 1'b0; k = 0;
    while (!fin && k < 400) begin
      halt  = 1'b0;
      start = 1'b0;
      if (done) begin
        fin = 1'b1;
      end else if (!load_enable) begin
        if (busy && cpu_reset && !s_ready) prime++;
        else if (fetch && !rw) begin
          fill++;
          if (fill == halt_fill) halt = 1'b1;
        end else if (fetch && rw) begin
          run++;
          if (run == halt_run) halt = 1'b1;
          if (run == start_run) begin
            start    = 1'b1;
            prog_len = '0;
          end
        end else if (!fetch && rw) drain++;
      end
      if (!fin) begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    total++; if ({busy, done, err, s_ready, load_enable, fetch, rw} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000000", {busy, done, err, s_ready, load_enable, fetch, rw}); end
    total++; if ({cycle_count, base_pc, load_address, load_data} !== 128'b0) begin
      bad++; $display("FAIL reset_values got cc=%h pc=%h a=%h d=%h exp=0", cycle_count, base_pc, load_address, load_data); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int p, f, r, d, s0;
    bit fin;
    s0 = strobes;
    do_start(9'd3, 32'h100, 16'd10);
    total++; if (busy !== 1'b1 || cpu_reset !== 1'b1) begin
      bad++; $display("FAIL basic_load_state busy=%b cpu_reset=%b exp 1 1", busy, cpu_reset); end
    feed(3, 32'h100, 1'b0);
    run_phases(0, 0, 0, p, f, r, d, fin);
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL basic_timeout done=%b exp=1", done); end
    total++; if (strobes - s0 !== 3) begin bad++; $display("FAIL basic_strobes got=%0d exp=3", strobes - s0); end
    total++; if (p !== 1) begin bad++; $display("FAIL basic_prime got=%0d exp=1", p); end
    total++; if (f !== 4) begin bad++; $display("FAIL basic_fill got=%0d exp=4", f); end
    total++; if (r !== 10) begin bad++; $display("FAIL basic_run got=%0d exp=10", r); end
    total++; if (d !== 4) begin bad++; $display("FAIL basic_drain got=%0d exp=4", d); end
    total++; if (cycle_count !== 32'd18) begin bad++; $display("FAIL basic_cycles got=%0d exp=18", cycle_count); end
    total++; if (base_pc !== 32'h100) begin bad++; $display("FAIL basic_base_pc got=%h exp=100", base_pc); end
    total++; if ({done, err, cpu_reset, busy, fetch, rw} !== 6'b100000) begin
      bad++; $display("FAIL basic_done_flags got=%b exp=100000", {done, err, cpu_reset, busy, fetch, rw}); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL basic_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_stall();
    int p, f, r, d, s0;
    bit fin;
    s0 = strobes;
    do_start(9'd4, 32'h2000, 16'd3);
    feed(4, 32'h2000, 1'b1);
    run_phases(0, 0, 0, p, f, r, d, fin);
    total++; if (strobes - s0 !== 4) begin bad++; $display("FAIL stall_strobes got=%0d exp=4", strobes - s0); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL stall_sb_left got=%0d exp=0", sb.size()); end
    total++; if (fin !== 1'b1 || r !== 3) begin bad++; $display("FAIL stall_run fin=%b run=%0d exp 1 3", fin, r); end
    total++; if (cycle_count !== 32'd11) begin bad++; $display("FAIL stall_cycles got=%0d exp=11", cycle_count); end
  endtask

  task automatic test_halt_run();
    int p, f, r, d;
    bit fin;
    do_start(9'd2, 32'h800, 16'd0);
    feed(2, 32'h800, 1'b0);
    run_phases(0, 5, 2, p, f, r, d, fin);
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL halt_run_timeout done=%b exp=1", done); end
    total++; if (r !== 5) begin bad++; $display("FAIL halt_run_run got=%0d exp=5", r); end
    total++; if (d !== 4) begin bad++; $display("FAIL halt_run_drain got=%0d exp=4", d); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL halt_run_err got=%b exp=0", err); end
    total++; if (cycle_count !== 32'd13) begin bad++; $display("FAIL halt_run_cycles got=%0d exp=13", cycle_count); end
  endtask

  task automatic test_halt_fill();
    int p, f, r, d;
    bit fin;
    do_start(9'd2, 32'hFFFF_FFFC, 16'd7);
    feed(2, 32'hFFFF_FFFC, 1'b0);
    run_phases(2, 0, 0, p, f, r, d, fin);
    total++; if (f !== 2 || r !== 0) begin bad++; $display("FAIL halt_fill_phases fill=%0d run=%0d exp 2 0", f, r); end
    total++; if (d !== 4) begin bad++; $display("FAIL halt_fill_drain got=%0d exp=4", d); end
    total++; if (cycle_count !== 32'd6) begin bad++; $display("FAIL halt_fill_cycles got=%0d exp=6", cycle_count); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL halt_fill_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_bad_len();
    logic [8:0] lens[2];
    int s0;
    lens[0] = 9'd0;
    lens[1] = 9'd257;
    for (int i = 0; i < 2; i++) begin
      s0 = strobes;
      do_start(lens[i], 32'h4000, 16'd5);
      total++; if ({done, err, cpu_reset, busy, s_ready} !== 5'b11100) begin
        bad++; $display("FAIL bad_len_%0d flags got=%b exp=11100", lens[i], {done, err, cpu_reset, busy, s_ready}); end
      repeat (3) @(negedge clk);
      total++; if (strobes - s0 !== 0 || cpu_reset !== 1'b1) begin
        bad++; $display("FAIL bad_len_%0d_hold strobes=%0d cpu_reset=%b exp 0 1", lens[i], strobes - s0, cpu_reset); end
    end
  endtask

  task automatic test_halt_load();
    int s0;
    s0 = strobes;
    do_start(9'd3, 32'h500, 16'd5);
    feed(1, 32'h500, 1'b0);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    total++; if ({done, err, cpu_reset, busy, s_ready} !== 5'b11100) begin
      bad++; $display("FAIL halt_load_flags got=%b exp=11100", {done, err, cpu_reset, busy, s_ready}); end
    repeat (2) @(negedge clk);
    total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL halt_load_strobes got=%0d exp=1", strobes - s0); end
  endtask

  task automatic test_reset_midload();
    int p, f, r, d, s0;
    bit fin;
    do_start(9'd4, 32'h3000, 16'd5);
    feed(2, 32'h3000, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if ({cpu_reset, busy, s_ready, load_enable, done} !== 5'b10000) begin
      bad++; $display("FAIL midload_reset_flags got=%b exp=10000", {cpu_reset, busy, s_ready, load_enable, done}); end
    total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL midload_reset_cycles got=%0d exp=0", cycle_count); end
    reset_n = 1'b1;
    s0 = strobes;
    do_start(9'd2, 32'h40, 16'd1);
    feed(2, 32'h40, 1'b0);
    run_phases(0, 0, 0, p, f, r, d, fin);
    total++; if (strobes - s0 !== 2) begin bad++; $display("FAIL midload_reload_strobes got=%0d exp=2", strobes - s0); end
    total++; if (fin !== 1'b1 || r !== 1) begin bad++; $display("FAIL midload_run fin=%b run=%0d exp 1 1", fin, r); end
    total++; if (cycle_count !== 32'd9) begin bad++; $display("FAIL midload_cycles got=%0d exp=9", cycle_count); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL midload_sb_left got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_halt_run();
    test_halt_fill();
    test_bad_len();
    test_halt_load();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
